// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU codes,
// mux selects, FSM states and the per-state Moore control word.
package mc_control_fsm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_XOR = 3'b100;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RDA   = 2'b10;

    localparam logic [1:0] SRCB_RDB  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word for a state; anything not listed stays at zero,
    // which also makes S_RESET and S_TRAP assert no enables at all.
    function automatic ctrl_t state_ctrl(input state_t s, input logic is_store);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_B;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RDA;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = is_store ? IMM_S : IMM_I;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RDA;
                c.alu_src_b = SRCB_RDB;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RDA;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RDA;
                c.alu_src_b  = SRCB_RDB;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational ALU decoder: turns ALUOp plus instruction fields into the
// 3-bit ALUControl code the ALU consumes.
module mc_control_fsm_alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                // funct7b5 only means SUB for register-register ops; addi ignores it
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control = ALUC_SLT;
                    3'b100:  alu_control = ALUC_XOR;
                    3'b110:  alu_control = ALUC_OR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives datapath enables and mux selects.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter bit RESET_TO_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   branch_taken;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:  if (RESET_TO_FETCH || start) state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: state_nxt = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_EXECR:  state_nxt = S_ALUWB;
            S_EXECI:  state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_JAL:    state_nxt = S_ALUWB;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_RESET;
        endcase
    end

    // The control word is registered for the state being entered, so it lines up
    // with that state and an async reset clears every enable immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RESET;
            ctrl          <= '0;
            illegal_instr <= 1'b0;
        end else begin
            state <= state_nxt;
            ctrl  <= state_ctrl(state_nxt, op == OP_STORE);
            if (state_nxt == S_TRAP) begin
                illegal_instr <= 1'b1;
            end
        end
    end

    // Fetch and branch enables depend on same-cycle memory/ALU feedback.
    assign branch_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
    assign IRWrite      = (state == S_FETCH) && mem_ready;
    assign PCWrite      = IRWrite || (state == S_JAL) || ((state == S_BRANCH) && branch_taken);

    assign AdrSrc    = ctrl.adr_src;
    assign MemWrite  = ctrl.mem_write;
    assign RegWrite  = ctrl.reg_write;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ImmSrc    = ctrl.imm_src;

    mc_control_fsm_alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm: walks every instruction class
// through the FSM and compares the full control word per cycle.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    logic       pc_write_2, adr_src_2, mem_write_2, ir_write_2, reg_write_2, illegal_2;
    logic [1:0] result_src_2, alu_src_a_2, alu_src_b_2, imm_src_2;
    logic [2:0] alu_control_2;

    int compared   = 0;
    int mismatched = 0;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
    localparam logic [16:0] SIG_RESET      = 17'b0_0_0_0_0_00_00_00_00_000_0;
    localparam logic [16:0] SIG_FETCH_GO   = 17'b1_0_0_1_0_10_00_10_00_000_0;
    localparam logic [16:0] SIG_FETCH_WAIT = 17'b0_0_0_0_0_10_00_10_00_000_0;
    localparam logic [16:0] SIG_DECODE     = 17'b0_0_0_0_0_00_01_01_10_000_0;
    localparam logic [16:0] SIG_MEMADR_LW  = 17'b0_0_0_0_0_00_10_01_00_000_0;
    localparam logic [16:0] SIG_MEMADR_SW  = 17'b0_0_0_0_0_00_10_01_01_000_0;
    localparam logic [16:0] SIG_MEMRD      = 17'b0_1_0_0_0_00_00_00_00_000_0;
    localparam logic [16:0] SIG_MEMWB      = 17'b0_0_0_0_1_01_00_00_00_000_0;
    localparam logic [16:0] SIG_MEMWR      = 17'b0_1_1_0_0_00_00_00_00_000_0;
    localparam logic [16:0] SIG_EXECR_SUB  = 17'b0_0_0_0_0_00_10_00_00_001_0;
    localparam logic [16:0] SIG_EXECI      = 17'b0_0_0_0_0_00_10_01_00_000_0;
    localparam logic [16:0] SIG_ALUWB      = 17'b0_0_0_0_1_00_00_00_00_000_0;
    localparam logic [16:0] SIG_BRANCH_NT  = 17'b0_0_0_0_0_00_10_00_00_001_0;
    localparam logic [16:0] SIG_JAL        = 17'b1_0_0_0_0_00_01_10_00_000_0;
    localparam logic [16:0] SIG_TRAP       = 17'b0_0_0_0_0_00_00_00_00_000_1;

    logic [16:0] sig;
    logic [16:0] sig_2;
    assign sig   = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                    alu_src_a, alu_src_b, imm_src, alu_control, illegal};
    assign sig_2 = {pc_write_2, adr_src_2, mem_write_2, ir_write_2, reg_write_2, result_src_2,
                    alu_src_a_2, alu_src_b_2, imm_src_2, alu_control_2, illegal_2};

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pc_write), .AdrSrc(adr_src), .MemWrite(mem_write), .IRWrite(ir_write),
        .RegWrite(reg_write), .ResultSrc(result_src), .ALUSrcA(alu_src_a),
        .ALUSrcB(alu_src_b), .ImmSrc(imm_src), .ALUControl(alu_control),
        .illegal_instr(illegal)
    );

    mc_control_fsm #(.RESET_TO_FETCH(1'b0)) dut_hold (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pc_write_2), .AdrSrc(adr_src_2), .MemWrite(mem_write_2), .IRWrite(ir_write_2),
        .RegWrite(reg_write_2), .ResultSrc(result_src_2), .ALUSrcA(alu_src_a_2),
        .ALUSrcB(alu_src_b_2), .ImmSrc(imm_src_2), .ALUControl(alu_control_2),
        .illegal_instr(illegal_2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic rdy);
        op        = o;
        funct3    = f3;
        funct7b5  = f7;
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    // Starts in FETCH; counts cycles until the next fetch handshake.
    task automatic runLatency(input string tag, input logic [6:0] o, input logic [2:0] f3,
                              input int expected);
        int n;
        applyStimulus(o, f3, 1'b0, 1'b1, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ir_write && n < 20);
        checkOutput(tag, n, expected);
    endtask

    logic [2:0] rF3[6]  = '{3'b111, 3'b110, 3'b100, 3'b010, 3'b011, 3'b000};
    logic [2:0] rAlu[6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b000, 3'b000};
    logic [2:0] bF3[5]  = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
    logic       bZero[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       bTaken[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
        #11;
        checkOutput("reset_outputs", sig, SIG_RESET);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_state_cycle", sig, SIG_RESET);
        tick();

        // lw walk-through
        checkOutput("lw_fetch", sig, SIG_FETCH_GO);
        tick(); checkOutput("lw_decode", sig, SIG_DECODE);
        tick(); checkOutput("lw_memadr", sig, SIG_MEMADR_LW);
        tick(); checkOutput("lw_memrd", sig, SIG_MEMRD);
        tick(); checkOutput("lw_memwb", sig, SIG_MEMWB);
        tick(); checkOutput("lw_back_fetch", sig, SIG_FETCH_GO);

        // R-type sub and I-type addi with funct7b5 set
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
        tick(); checkOutput("r_decode", sig, SIG_DECODE);
        tick(); checkOutput("r_execr_sub", sig, SIG_EXECR_SUB);
        tick(); checkOutput("r_aluwb", sig, SIG_ALUWB);
        tick(); checkOutput("r_back_fetch", sig, SIG_FETCH_GO);
        applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
        tick(); tick(); checkOutput("i_execi_add", sig, SIG_EXECI);
        tick(); checkOutput("i_aluwb", sig, SIG_ALUWB);
        tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(7'b0110011, rF3[i], 1'b0, 1'b0, 1'b1);
            tick(); tick();
            checkOutput($sformatf("r_alu_f3_%0d", i), alu_control, rAlu[i]);
            tick(); tick();
        end

        // Branch taken/not-taken for beq, bne and an unsupported funct3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(7'b1100011, bF3[i], 1'b0, bZero[i], 1'b1);
            tick(); tick();
            checkOutput($sformatf("branch_%0d", i), sig, {bTaken[i], SIG_BRANCH_NT[15:0]});
            tick();
        end

        // Fetch stall for three cycles, then sw held two extra cycles
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("fetch_stall_%0d", i), sig, SIG_FETCH_WAIT);
            tick();
        end
        mem_ready = 1'b1; #1;
        checkOutput("fetch_release", sig, SIG_FETCH_GO);
        tick(); checkOutput("sw_decode", sig, SIG_DECODE);
        tick(); checkOutput("sw_memadr", sig, SIG_MEMADR_SW);
        tick(); mem_ready = 1'b0; #1;
        checkOutput("sw_memwr_0", sig, SIG_MEMWR);
        tick(); checkOutput("sw_memwr_1", sig, SIG_MEMWR);
        tick(); mem_ready = 1'b1; #1;
        checkOutput("sw_memwr_2", sig, SIG_MEMWR);
        tick(); checkOutput("sw_back_fetch", sig, SIG_FETCH_GO);

        // jal
        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("jal_decode", sig, SIG_DECODE);
        tick(); checkOutput("jal_state", sig, SIG_JAL);
        tick(); checkOutput("jal_aluwb", sig, SIG_ALUWB);
        tick(); checkOutput("jal_back_fetch", sig, SIG_FETCH_GO);

        runLatency("lat_lw", 7'b0000011, 3'b010, 5);
        runLatency("lat_sw", 7'b0100011, 3'b010, 4);
        runLatency("lat_r", 7'b0110011, 3'b000, 4);
        runLatency("lat_i", 7'b0010011, 3'b000, 4);
        runLatency("lat_branch", 7'b1100011, 3'b000, 3);
        runLatency("lat_jal", 7'b1101111, 3'b000, 4);

        // Unsupported opcode traps until reset
        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("trap_decode", sig, SIG_DECODE);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("trap_hold_%0d", i), sig, SIG_TRAP);
        end
        rst_n = 1'b0; #1;
        checkOutput("trap_reset_clears", sig, SIG_RESET);
        @(negedge clk); rst_n = 1'b1;
        tick(); applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        checkOutput("post_trap_fetch", sig, SIG_FETCH_GO);

        // Reset in the middle of a pending store
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        checkOutput("abort_memwr_pre", sig, SIG_MEMWR);
        rst_n = 1'b0; #1;
        checkOutput("abort_memwrite", mem_write, 1'b0);
        checkOutput("abort_all", sig, SIG_RESET);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // RESET_TO_FETCH=0 instance waits for start
        mem_ready = 1'b1;
        tick(); tick(); #1;
        checkOutput("hold_no_start", sig_2, SIG_RESET);
        start = 1'b1;
        tick(); #1;
        checkOutput("hold_after_start", sig_2, SIG_FETCH_GO);
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
